// File: rtl/program_counter_pkg.sv
// Shared core constants for the RV32I program counter.
package program_counter_pkg;

  // Architectural register width of the core.
  localparam int unsigned PC_XLEN = 32;

  // Address fetched first after reset.
  localparam logic [PC_XLEN-1:0] PC_RESET_VECTOR = 32'h0000_0000;

  // Every RV32I instruction is 4 bytes; its address must be a multiple of this.
  localparam int unsigned INSTR_BYTES = 4;

  // Number of low PC bits that must be zero for an aligned fetch.
  localparam int unsigned INSTR_ALIGN_BITS = $clog2(INSTR_BYTES);

endpackage : program_counter_pkg

// File: rtl/program_counter.sv
// Architectural PC register: captures the next-PC every edge and exposes the
// sequential increment and a fetch-alignment flag derived from the current PC.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned        XLEN         = PC_XLEN,
  parameter logic [XLEN-1:0]    RESET_VECTOR = XLEN'(PC_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PC_in,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] PC_plus4,
  output logic            misaligned
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_misaligned;

  // PC register: reset vector while reset is low, otherwise the next-PC verbatim.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= PC_in;
    end
  end

  // Sequential increment (wraps modulo 2^XLEN) and low-bit alignment check.
  always_comb begin
    w_pc_plus4   = r_pc + XLEN'(INSTR_BYTES);
    w_misaligned = |r_pc[INSTR_ALIGN_BITS-1:0];
  end

  assign PC_out     = r_pc;
  assign PC_plus4   = w_pc_plus4;
  assign misaligned = w_misaligned;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_program_counter;

  logic        clk;
  logic        reset;
  logic [31:0] PC_in;
  logic [31:0] PC_out;
  logic [31:0] PC_plus4;
  logic        misaligned;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state: value the PC must hold after the most recent rising edge.
  logic [31:0] m_pc;
  bit          m_valid = 1'b0;

  program_counter #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PC_in(PC_in),
    .PC_out(PC_out),
    .PC_plus4(PC_plus4),
    .misaligned(misaligned)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: whatever is present at the edge is what the PC becomes.
  always @(posedge clk) begin
    if (reset === 1'b0) begin
      m_pc    = 32'h0000_0000;
      m_valid = 1'b1;
    end else begin
      m_pc = PC_in;
    end
  end

  // Per-cycle comparison on the falling edge, once the PC is defined.
  always @(negedge clk) begin
    logic [32:0] sum;
    if (m_valid) begin
      sum = {1'b0, m_pc} + 33'd4;
      check("pc_out",     PC_out,   m_pc);
      check("pc_plus4",   PC_plus4, sum[31:0]);
      check("misaligned", {31'b0, misaligned}, {31'b0, (m_pc % 4) != 0});
    end
  end

  // Advance to 3 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    reset = 1'b0;
    PC_in = 32'h0000_0010;

    // Reset held for two edges.
    tick();
    tick();
    check("rst_pc",    PC_out,   32'h0000_0000);
    check("rst_plus4", PC_plus4, 32'h0000_0004);
    check("rst_mis",   {31'b0, misaligned}, 32'd0);

    // Load a misaligned value.
    reset = 1'b1;
    PC_in = 32'h0198_06B3;
    tick();
    check("load_pc",    PC_out,   32'h0198_06B3);
    check("load_plus4", PC_plus4, 32'h0198_06B7);
    check("load_mis",   {31'b0, misaligned}, 32'd1);

    // Mid-run reset then release.
    reset = 1'b0;
    tick();
    check("midrst_pc", PC_out, 32'h0000_0000);
    reset = 1'b1;
    PC_in = 32'h0051_E233;
    tick();
    check("release_pc", PC_out, 32'h0051_E233);

    // Sequential value held across several edges.
    PC_in = 32'd12;
    tick();
    check("seq_pc",    PC_out,   32'd12);
    check("seq_plus4", PC_plus4, 32'd16);
    check("seq_mis",   {31'b0, misaligned}, 32'd0);
    tick();
    tick();
    check("hold_pc", PC_out, 32'd12);

    // Wrap of the increment.
    PC_in = 32'hFFFF_FFFC;
    tick();
    check("wrap_pc",    PC_out,   32'hFFFF_FFFC);
    check("wrap_plus4", PC_plus4, 32'h0000_0000);

    // Toggles between edges: only the value at the edge is captured.
    PC_in = 32'h0000_0100;
    #4;
    PC_in = 32'h0000_0204;
    check("between_hold", PC_out, 32'hFFFF_FFFC);
    #1;
    PC_in = 32'h0000_0308;
    tick();
    check("between_cap", PC_out, 32'h0000_0308);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 15) != 0);
      case ($urandom_range(0, 7))
        0:       PC_in = 32'hFFFF_FFFC;
        1, 2:    PC_in = $urandom & 32'hFFFF_FFFC;
        default: PC_in = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        #4;
        PC_in = $urandom;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_program_counter

// File: doc/program_counter.md
Name: program_counter

Overview:
Architectural program-counter register for the single-cycle RV32I core. It captures the next-PC value (PC_in) on each rising clock edge and presents it as PC_out to instruction memory and the datapath. It also provides a sequential-increment value and an alignment flag for the fetch stage. It sits between the next-PC mux (branch/jump/PC+4 select) and instruction fetch.

Parameters:
XLEN, 32, width of PC_in, PC_out and PC_plus4.
RESET_VECTOR, 32'h0000_0000, value loaded into PC_out while reset is asserted.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset; reset==0 at a rising clk edge loads RESET_VECTOR.
PC_in  input  XLEN  next-PC value from the next-PC mux.
PC_out  output  XLEN  current PC (registered).
PC_plus4  output  XLEN  combinational PC_out + 4, modulo 2^XLEN.
misaligned  output  1  combinational; 1 when PC_out[1:0] != 2'b00.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-low; the port is named reset. Reset is sampled only at rising clk edges and never acts asynchronously.
- At a rising edge with reset==0: PC_out <= RESET_VECTOR. PC_in is ignored.
- At a rising edge with reset==1: PC_out <= PC_in, copied verbatim. No masking or alignment of the low bits.
- Latency: PC_in is visible on PC_out exactly one rising edge after it is sampled. PC_in changes between edges have no effect.
- Reset values: PC_out = RESET_VECTOR, PC_plus4 = RESET_VECTOR + 4, misaligned = |RESET_VECTOR[1:0] (0 for the default).
- Power-up before the first reset edge: PC_out is undefined. Benches must apply reset==0 for at least one edge.
- Reset mid-run: asserting reset on any edge discards the current PC and loads RESET_VECTOR on that edge. On the first edge with reset==1 afterwards, PC_out <= PC_in.
- PC_plus4 wraps: PC_out = 32'hFFFF_FFFC gives PC_plus4 = 32'h0000_0000. There is no overflow flag.
- misaligned is purely combinational from PC_out. It is informational only and does not block the PC update.
- No enable or stall input. The PC updates on every edge.
- No combinational path from PC_in to any output.

Decomposition:
- Shared core package: XLEN = 32, RESET_VECTOR default, and the instruction-alignment constant (4 bytes).
- No sub-module. The block is a single register plus an adder and a compare.

Test Plan:
- Reset: hold reset=0 for 2 edges with PC_in=32'h0000_0010 -> PC_out=0, PC_plus4=4, misaligned=0.
- Load: reset=1, PC_in=32'h0198_06B3 -> PC_out=32'h0198_06B3 after the next edge; misaligned=1 because the low bits are 2'b11.
- Mid-run reset: with PC_out=32'h0198_06B3, drive reset=0 for one edge -> PC_out=0. Release reset with PC_in=32'h0051_E233 -> PC_out=32'h0051_E233 on the following edge.
- Sequential: reset=1, PC_in=32'd12 -> PC_out=12, PC_plus4=16, misaligned=0. PC_out holds 12 on subsequent edges while PC_in stays 12.
- Wrap: PC_in=32'hFFFF_FFFC -> PC_out=32'hFFFF_FFFC, PC_plus4=32'h0000_0000.
- Between edges: toggle PC_in mid-cycle -> PC_out does not change until the next rising edge; only the value present at the edge is captured.
